serial_demux_rx: RTL and testbench
==================================

# serial_demux_rx

Serial-to-parallel receiver: the demultiplexing end of the bit-serial link whose transmit side time-multiplexes a parallel word onto one wire. Collects WIDTH framed bits from a single serial line, LSB first, into a parallel word, then presents it to a downstream consumer with a valid/ready handshake. Flags framing, overrun and (optionally) parity errors. Sits between the serial link pins and the lab datapath registers.

## Interface
- WIDTH, 8, data bits per frame (2..32)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- sin  input  1  serial data bit
- sin_valid  input  1  sin carries a bit this cycle
- frame_start  input  1  qualifies the current sin bit as bit 0 of a frame; ignored when sin_valid=0
- out_ready  input  1  consumer accepts pout this cycle
- pout  output  WIDTH  received word, bit i = i-th received bit
- pout_valid  output  1  pout holds a complete word
- frame_err  output  1  one-cycle error pulse
- busy  output  1  state != IDLE

One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, SHIFT, PAR (only with PARITY_EN), HOLD. Bit counter cnt, width $clog2(WIDTH).
- An accepted bit is one with sin_valid=1 at a rising clk edge.
- IDLE: accepted bit with frame_start=1 -> store sin in pout[0], cnt=1, go SHIFT. Accepted bit with frame_start=0 -> discarded, no error.
- SHIFT: accepted bit, frame_start=0 -> pout[cnt]=sin, cnt+1. When the bit at index WIDTH-1 is stored -> HOLD (or PAR with PARITY_EN).
- SHIFT, accepted bit with frame_start=1 (resync) -> frame_err pulse, bit stored as pout[0], cnt=1, stay SHIFT.
- HOLD: pout_valid=1, pout stable. out_ready=1 -> transfer; next state IDLE, or SHIFT if an accepted frame_start bit arrives the same cycle (stored as pout[0]: zero-bubble back-to-back).
- HOLD, accepted bit without transfer -> bit dropped, frame_err pulse (overrun); word kept.
- Accepted bits with frame_start=0 in HOLD during a transfer cycle -> dropped, frame_err pulse.
- Contents of pout outside HOLD are not specified; consumers sample only when pout_valid=1.
- Reset (any time, including mid-frame or during HOLD): state IDLE, cnt=0, pout=0, pout_valid=0, frame_err=0, busy=0; the partial or held word is lost.

## Timing
- All outputs registered.
- pout_valid rises the edge that accepts the last data bit (or the parity bit); first visible the following cycle.
- Minimum frame period WIDTH cycles (WIDTH+1 with PARITY_EN) at continuous sin_valid with out_ready held 1.
- pout_valid falls the edge where out_ready=1 is sampled in HOLD.
- frame_err asserted exactly one cycle per error event, registered on the accepting edge.
- sin_valid gaps in SHIFT/PAR stall the frame with no timeout.

## Configuration
- PARITY_RX_EN defined: after data bit WIDTH-1, state PAR accepts one parity bit. Even parity: XOR of the WIDTH data bits and the parity bit must be 0 -> HOLD. Mismatch -> frame_err pulse, IDLE, pout_valid stays 0. frame_start=1 on the parity bit -> resync as in SHIFT.
- Undefined: no PAR state, frames are exactly WIDTH bits, no parity logic.

## Test plan
- Reset mid-frame: rst_n low after 3 bits -> all outputs 0 immediately; a following full frame of 0x3C received correctly.
- WIDTH=8, out_ready=1, send 0xA5 LSB first (1,0,1,0,0,1,0,1), frame_start on first bit -> pout=0xA5, pout_valid high one cycle, frame_err never set.
- Back-to-back 0x01 then 0xFF, continuous sin_valid, out_ready=1 -> two valid words 8 cycles apart, no dropped bits.
- out_ready=0 after 0x5A, then 3 more bits -> pout holds 0x5A, three frame_err pulses; out_ready=1 -> transfer, busy drops.
- frame_start re-asserted on bit 4 of a frame, then 8 bits of 0xC3 -> one frame_err pulse, pout=0xC3.
- PARITY_RX_EN: 0x07 + parity 1 -> valid 0x07; 0x07 + parity 0 -> frame_err pulse, no pout_valid.

Source files
------------

// File: rtl/serial_demux_rx_if.sv
// Purpose : bundles the serial link input and the parallel word output of serial_demux_rx.
// Ports   : sin/sin_valid/frame_start carry the serial bit stream, out_ready is the consumer accept.
//           pout/pout_valid/frame_err/busy form the received-word side.
//           master = link driver / consumer side; slave = the receiver itself.
interface serial_demux_rx_if #(
   parameter int WIDTH = 8
);
   logic             sin;
   logic             sin_valid;
   logic             frame_start;
   logic             out_ready;
   logic [WIDTH-1:0] pout;
   logic             pout_valid;
   logic             frame_err;
   logic             busy;

   modport master (
      output sin, sin_valid, frame_start, out_ready,
      input  pout, pout_valid, frame_err, busy
   );

   modport slave (
      input  sin, sin_valid, frame_start, out_ready,
      output pout, pout_valid, frame_err, busy
   );
endinterface

// File: rtl/serial_demux_rx.sv
// Purpose : serial-to-parallel receiver, WIDTH framed bits LSB first into a parallel word.
// Latency : pout_valid registered on the edge accepting the last data bit (parity bit when PARITY_RX_EN).
// Backpr. : word held in HOLD until out_ready; bits arriving meanwhile are dropped with a frame_err pulse.
// Ports   : clk, rst_n (async active-low); bus (slave modport of serial_demux_rx_if) carries
//           sin/sin_valid/frame_start/out_ready in and pout/pout_valid/frame_err/busy out.
// Option  : define PARITY_RX_EN to add an even-parity bit after the data bits (PAR state).
module serial_demux_rx #(
   parameter int WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   serial_demux_rx_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef PARITY_RX_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2,
      HOLD  = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd3
   } state_t;
`endif

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [WIDTH-1:0] r_pout;
   logic [WIDTH-1:0] w_pout_nxt;
   logic             r_frame_err;
   logic             w_err_nxt;
   logic             r_pout_valid;
   logic             r_busy;
   logic             w_acc;
   logic             w_fs;

   assign w_acc = bus.sin_valid;
   assign w_fs  = bus.sin_valid & bus.frame_start;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pout_nxt  = r_pout;
      w_err_nxt   = 1'b0;
      case (r_state)
         IDLE: begin
            // bits outside a frame are silently discarded
            if (w_fs) begin
               w_pout_nxt[0] = bus.sin;
               w_cnt_nxt     = CNT_ONE;
               w_state_nxt   = SHIFT;
            end
         end
         SHIFT: begin
            if (w_fs) begin
               // resync: abandon the partial word and restart on this bit
               w_err_nxt     = 1'b1;
               w_pout_nxt[0] = bus.sin;
               w_cnt_nxt     = CNT_ONE;
            end else if (w_acc) begin
               w_pout_nxt[r_cnt] = bus.sin;
               if (r_cnt == CNT_LAST) begin
                  w_cnt_nxt = '0;
`ifdef PARITY_RX_EN
                  w_state_nxt = PAR;
`else
                  w_state_nxt = HOLD;
`endif
               end else begin
                  w_cnt_nxt = r_cnt + CNT_ONE;
               end
            end
         end
`ifdef PARITY_RX_EN
         PAR: begin
            if (w_fs) begin
               w_err_nxt     = 1'b1;
               w_pout_nxt[0] = bus.sin;
               w_cnt_nxt     = CNT_ONE;
               w_state_nxt   = SHIFT;
            end else if (w_acc) begin
               // even parity over data plus parity bit
               if ((^r_pout ^ bus.sin) == 1'b0) begin
                  w_state_nxt = HOLD;
               end else begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
         end
`endif
         HOLD: begin
            if (bus.out_ready) begin
               if (w_fs) begin
                  // zero-bubble: next frame starts on the transfer cycle
                  w_pout_nxt[0] = bus.sin;
                  w_cnt_nxt     = CNT_ONE;
                  w_state_nxt   = SHIFT;
               end else begin
                  w_state_nxt = IDLE;
                  w_err_nxt   = w_acc;
               end
            end else begin
               // overrun: keep the held word, drop the incoming bit
               w_err_nxt = w_acc;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_pout       <= '0;
         r_frame_err  <= 1'b0;
         r_pout_valid <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_pout       <= w_pout_nxt;
         r_frame_err  <= w_err_nxt;
         // flags follow the next state so they line up with it
         r_pout_valid <= (w_state_nxt == HOLD);
         r_busy       <= (w_state_nxt != IDLE);
      end
   end

   assign bus.pout       = r_pout;
   assign bus.pout_valid = r_pout_valid;
   assign bus.frame_err  = r_frame_err;
   assign bus.busy       = r_busy;

endmodule

// File: tb/tb_serial_demux_rx.sv
// Purpose : directed self-checking bench for serial_demux_rx (WIDTH=8).
// Latency : inputs driven 1 time unit after each rising edge, outputs sampled there too.
// Backpr. : out_ready driven per test; error and valid pulses counted on falling edges.
module tb_serial_demux_rx;

`ifdef PARITY_RX_EN
   localparam int PERIOD = 9;
`else
   localparam int PERIOD = 8;
`endif

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   int   cyc;
   int   err_cnt;
   int   pv_cnt;
   logic [7:0] q_word[$];
   int         q_cyc[$];

   serial_demux_rx_if #(.WIDTH(8)) bus ();

   serial_demux_rx #(.WIDTH(8)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.frame_err === 1'b1) err_cnt <= err_cnt + 1;
      if (bus.pout_valid === 1'b1) begin
         pv_cnt <= pv_cnt + 1;
         q_word.push_back(bus.pout);
         q_cyc.push_back(cyc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic b, input logic fs);
      bus.sin         = b;
      bus.sin_valid   = 1'b1;
      bus.frame_start = fs;
      @(posedge clk);
      #1;
      bus.sin_valid   = 1'b0;
      bus.frame_start = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.sin_valid   = 1'b0;
      bus.frame_start = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // data bits LSB first; a correct even-parity bit follows when parity is built in
   task automatic send_word(input logic [7:0] w);
      for (int i = 0; i < 8; i++) send_bit(w[i], i == 0);
`ifdef PARITY_RX_EN
      send_bit(^w, 1'b0);
`endif
   endtask

   initial begin
      int e0, p0, qb;
      logic [7:0] pat;
      n_tests = 0; n_fail = 0; cyc = 0; err_cnt = 0; pv_cnt = 0;
      rst_n = 1'b0;
      bus.sin = 1'b0; bus.sin_valid = 1'b0; bus.frame_start = 1'b0; bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_pout", bus.pout, 0);
      check("rst_pvld", bus.pout_valid, 0);
      check("rst_ferr", bus.frame_err, 0);
      check("rst_busy", bus.busy, 0);
      rst_n = 1'b1;
      idle(1);

      // reset mid-frame, then a clean 0x3C
      send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
      check("mid_busy", bus.busy, 1);
      rst_n = 1'b0;
      #2;
      check("mid_rst_pout", bus.pout, 0);
      check("mid_rst_pvld", bus.pout_valid, 0);
      check("mid_rst_ferr", bus.frame_err, 0);
      check("mid_rst_busy", bus.busy, 0);
      rst_n = 1'b1;
      send_word(8'h3C);
      check("w3c_pvld", bus.pout_valid, 1);
      check("w3c_pout", bus.pout, 32'h3C);
      idle(1);
      check("w3c_pvld_drop", bus.pout_valid, 0);

      // discard a non-start bit in IDLE
      e0 = err_cnt;
      send_bit(1'b1, 1'b0);
      check("idle_disc_busy", bus.busy, 0);
      idle(1);
      check("idle_disc_err", err_cnt - e0, 0);

      // 0xA5 single frame
      e0 = err_cnt; p0 = pv_cnt;
      send_word(8'hA5);
      check("a5_pvld", bus.pout_valid, 1);
      check("a5_pout", bus.pout, 32'hA5);
      idle(2);
      check("a5_pvld_cycles", pv_cnt - p0, 1);
      check("a5_err", err_cnt - e0, 0);
      check("a5_busy", bus.busy, 0);

      // back-to-back 0x01 then 0xFF
      e0 = err_cnt; qb = q_word.size();
      send_word(8'h01);
      send_word(8'hFF);
      idle(2);
      check("b2b_count", q_word.size() - qb, 2);
      if (q_word.size() >= qb + 2) begin
         check("b2b_w0", q_word[qb], 32'h01);
         check("b2b_w1", q_word[qb+1], 32'hFF);
         check("b2b_gap", q_cyc[qb+1] - q_cyc[qb], PERIOD);
      end
      check("b2b_err", err_cnt - e0, 0);

      // overrun while held
      bus.out_ready = 1'b0;
      e0 = err_cnt;
      send_word(8'h5A);
      check("ovr_pvld", bus.pout_valid, 1);
      send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0);
      check("ovr_pout", bus.pout, 32'h5A);
      check("ovr_pvld_held", bus.pout_valid, 1);
      check("ovr_busy", bus.busy, 1);
      bus.out_ready = 1'b1;
      idle(1);
      check("ovr_errs", err_cnt - e0, 3);
      check("ovr_xfer_pvld", bus.pout_valid, 0);
      check("ovr_xfer_busy", bus.busy, 0);

      // resync on bit 4, then 0xC3
      e0 = err_cnt;
      pat = 8'h0F;
      for (int i = 0; i < 4; i++) send_bit(pat[i], i == 0);
      send_word(8'hC3);
      check("rsy_pvld", bus.pout_valid, 1);
      check("rsy_pout", bus.pout, 32'hC3);
      idle(1);
      check("rsy_errs", err_cnt - e0, 1);

      // sin_valid gap stalls the frame
      pat = 8'h96;
      for (int i = 0; i < 4; i++) send_bit(pat[i], i == 0);
      idle(3);
      check("gap_busy", bus.busy, 1);
      check("gap_pvld", bus.pout_valid, 0);
      for (int i = 4; i < 8; i++) send_bit(pat[i], 1'b0);
`ifdef PARITY_RX_EN
      send_bit(^pat, 1'b0);
`endif
      check("gap_pout", bus.pout, 32'h96);
      check("gap_pvld_end", bus.pout_valid, 1);
      idle(1);

`ifdef PARITY_RX_EN
      // good parity then bad parity on 0x07
      pat = 8'h07;
      e0 = err_cnt; p0 = pv_cnt;
      for (int i = 0; i < 8; i++) send_bit(pat[i], i == 0);
      send_bit(1'b1, 1'b0);
      check("par_ok_pvld", bus.pout_valid, 1);
      check("par_ok_pout", bus.pout, 32'h07);
      idle(1);
      for (int i = 0; i < 8; i++) send_bit(pat[i], i == 0);
      send_bit(1'b0, 1'b0);
      check("par_bad_ferr", bus.frame_err, 1);
      check("par_bad_pvld", bus.pout_valid, 0);
      check("par_bad_busy", bus.busy, 0);
      idle(2);
      check("par_pv_total", pv_cnt - p0, 1);
      check("par_err_total", err_cnt - e0, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
